// File: rtl/tv_gen_multi_if.sv
// Stimulus-generator bus: run control in from the bench, stimulus vector and status out.
// The generator takes the slave side; the sequencing bench takes the master side.
interface tv_gen_multi_if #(
  parameter int N_IN   = 2,
  parameter int HOLD_W = 8,
  parameter int CNT_W  = 16
);
  logic              start;
  logic              stop;
  logic [1:0]        mode;
  logic [HOLD_W-1:0] hold_len;
  logic [CNT_W-1:0]  rand_cnt;
  logic [N_IN-1:0]   vec;
  logic              vec_valid;
  logic [CNT_W-1:0]  vec_idx;
  logic              busy;
  logic              done;

  modport master (
    output start, stop, mode, hold_len, rand_cnt,
    input  vec, vec_valid, vec_idx, busy, done
  );

  modport slave (
    input  start, stop, mode, hold_len, rand_cnt,
    output vec, vec_valid, vec_idx, busy, done
  );
endinterface

// File: rtl/tv_gen_multi.sv
// Parametrised test-vector generator: binary, Gray, walking-one and LFSR sequences with
// programmable per-vector hold, start/stop handshake and a one-cycle done pulse.
module tv_gen_multi #(
  parameter int          N_IN   = 2,
  parameter int          HOLD_W = 8,
  parameter int          CNT_W  = 16,
  parameter logic [15:0] SEED   = 16'hACE1
) (
  input logic          clk,
  input logic          rst,
  tv_gen_multi_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef logic [N_IN-1:0] vec_t;

  state_t            state, state_nxt;
  logic [1:0]        mode_q;
  logic [HOLD_W-1:0] hold_q, hold_cnt, hold_in;
  logic [16:0]       total_q, total_in, pos, pos_nxt;
  logic [15:0]       lfsr, lfsr_nxt;
  vec_t              vec_r, vec_first, vec_adv;
  logic [CNT_W-1:0]  idx_r;
  logic              go, hold_end, last;

  // Position is tracked in 17 bits so a full 2^16 sweep terminates even when vec_idx saturates.
  always_comb begin
    go       = bus.start && !bus.stop;
    hold_end = (hold_cnt == hold_q - HOLD_W'(1));
    last     = (pos == total_q - 17'd1);
    pos_nxt  = pos + 17'd1;
    lfsr_nxt = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    hold_in  = (bus.hold_len == '0) ? HOLD_W'(1) : bus.hold_len;

    case (bus.mode)
      2'b00, 2'b01: total_in = 17'd1 << N_IN;
      2'b10:        total_in = 17'(N_IN);
      default:      total_in = (bus.rand_cnt == '0) ? 17'd1 : 17'(bus.rand_cnt);
    endcase

    case (bus.mode)
      2'b10:   vec_first = vec_t'(1);
      2'b11:   vec_first = lfsr[N_IN-1:0];
      default: vec_first = '0;
    endcase

    case (mode_q)
      2'b00:   vec_adv = pos_nxt[N_IN-1:0];
      2'b01:   vec_adv = pos_nxt[N_IN-1:0] ^ (pos_nxt[N_IN-1:0] >> 1);
      2'b10:   vec_adv = vec_t'(1) << pos_nxt;
      default: vec_adv = lfsr_nxt[N_IN-1:0];
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (go) state_nxt = RUN;
      RUN: begin
        if (bus.stop)              state_nxt = IDLE;
        else if (hold_end && last) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy      = (state == RUN);
    bus.vec_valid = (state == RUN);
    bus.done      = (state == DONE);
    bus.vec       = vec_r;
    bus.vec_idx   = idx_r;
  end

  // The LFSR is only restored to SEED by reset, so consecutive LFSR runs continue the sequence.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q   <= '0;
      hold_q   <= '0;
      hold_cnt <= '0;
      total_q  <= '0;
      pos      <= '0;
      lfsr     <= SEED;
      vec_r    <= '0;
      idx_r    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            mode_q   <= bus.mode;
            hold_q   <= hold_in;
            total_q  <= total_in;
            hold_cnt <= '0;
            pos      <= '0;
            idx_r    <= '0;
            vec_r    <= vec_first;
          end
        end
        RUN: begin
          if (bus.stop) begin
            vec_r    <= '0;
            idx_r    <= '0;
            hold_cnt <= '0;
          end else if (hold_end) begin
            hold_cnt <= '0;
            if (!last) begin
              pos   <= pos_nxt;
              vec_r <= vec_adv;
              if (idx_r != '1) idx_r <= idx_r + CNT_W'(1);
              if (mode_q == 2'b11) lfsr <= lfsr_nxt;
            end
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        default: begin
          vec_r <= '0;
          idx_r <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tv_gen_multi.sv
// Directed-plus-random bench for tv_gen_multi: a 4-bit instance covers all modes and the
// stop/reset cases, an 8-bit instance checks the LFSR byte sequence against a reference model.
module tb_tv_gen_multi;

  localparam int HOLD_W = 8;
  localparam int CNT_W  = 16;
  localparam logic [15:0] SEED = 16'hACE1;
  // Galois feedback mask derived from the polynomial exponents 16, 14, 13, 11.
  localparam logic [15:0] TAPS = 16'((1 << (16-1)) | (1 << (14-1)) | (1 << (13-1)) | (1 << (11-1)));

  logic clk = 1'b0;
  logic rst;
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  logic [15:0] lfsr4_m, lfsr8_m;

  always #5 clk = ~clk;

  tv_gen_multi_if #(.N_IN(4), .HOLD_W(HOLD_W), .CNT_W(CNT_W)) bus4 ();
  tv_gen_multi_if #(.N_IN(8), .HOLD_W(HOLD_W), .CNT_W(CNT_W)) bus8 ();

  tv_gen_multi #(.N_IN(4), .HOLD_W(HOLD_W), .CNT_W(CNT_W), .SEED(SEED)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4)
  );

  tv_gen_multi #(.N_IN(8), .HOLD_W(HOLD_W), .CNT_W(CNT_W), .SEED(SEED)) dut8 (
    .clk(clk), .rst(rst), .bus(bus8)
  );

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? TAPS : 16'h0000);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one sequence on the 4-bit instance and checks every cycle; stop_at >= 0 aborts there.
  task automatic applyStimulus(input logic [1:0] m, input int hold, input int rc, input int stop_at);
    logic [3:0]  exp_q[$];
    logic [15:0] hist[$];
    logic [15:0] l;
    logic [3:0]  prev;
    int t, h;
    h = (hold == 0) ? 1 : hold;
    case (m)
      2'd0, 2'd1: t = 16;
      2'd2:       t = 4;
      default:    t = (rc == 0) ? 1 : rc;
    endcase
    l = lfsr4_m;
    for (int k = 0; k < t; k++) begin
      case (m)
        2'd0:    exp_q.push_back(4'(k));
        2'd1:    exp_q.push_back(4'(k ^ (k >> 1)));
        2'd2:    exp_q.push_back(4'(1 << k));
        default: exp_q.push_back(l[3:0]);
      endcase
      hist.push_back(l);
      if (m == 2'd3) l = lfsr_step(l);
    end
    prev = '0;
    bus4.mode     = m;
    bus4.hold_len = HOLD_W'(hold);
    bus4.rand_cnt = CNT_W'(rc);
    bus4.start    = 1'b1;
    tick();
    bus4.start = 1'b0;
    for (int k = 0; k < t; k++) begin
      for (int c = 0; c < h; c++) begin
        checkOutput("run_vec",   32'(bus4.vec), 32'(exp_q[k]));
        checkOutput("run_valid", 32'(bus4.vec_valid), 32'd1);
        checkOutput("run_idx",   32'(bus4.vec_idx), 32'(k));
        checkOutput("run_busy",  32'(bus4.busy), 32'd1);
        checkOutput("run_done",  32'(bus4.done), 32'd0);
        if (m == 2'd1 && k > 0 && c == 0)
          checkOutput("gray_onebit", 32'($countones(bus4.vec ^ prev)), 32'd1);
        if (stop_at == k && c == 0) begin
          bus4.stop = 1'b1;
          tick();
          bus4.stop = 1'b0;
          checkOutput("stop_vec",   32'(bus4.vec), 32'd0);
          checkOutput("stop_valid", 32'(bus4.vec_valid), 32'd0);
          checkOutput("stop_busy",  32'(bus4.busy), 32'd0);
          checkOutput("stop_done",  32'(bus4.done), 32'd0);
          tick();
          checkOutput("stop_nodone", 32'(bus4.done), 32'd0);
          checkOutput("stop_idle",   32'(bus4.busy), 32'd0);
          if (m == 2'd3) lfsr4_m = hist[k];
          return;
        end
        prev = bus4.vec;
        bus4.mode     = 2'($urandom);
        bus4.hold_len = HOLD_W'($urandom);
        bus4.rand_cnt = CNT_W'($urandom);
        bus4.start    = 1'($urandom_range(0, 1));
        tick();
      end
    end
    bus4.start = 1'b0;
    checkOutput("done_pulse", 32'(bus4.done), 32'd1);
    checkOutput("done_busy",  32'(bus4.busy), 32'd0);
    checkOutput("done_valid", 32'(bus4.vec_valid), 32'd0);
    checkOutput("done_vec",   32'(bus4.vec), 32'(exp_q[t-1]));
    tick();
    checkOutput("post_done", 32'(bus4.done), 32'd0);
    checkOutput("post_busy", 32'(bus4.busy), 32'd0);
    checkOutput("post_valid", 32'(bus4.vec_valid), 32'd0);
    if (m == 2'd3) lfsr4_m = hist[t-1];
  endtask

  // LFSR run on the 8-bit instance; first_chk 1 expects the seed byte, 2 expects anything else.
  task automatic runLfsr8(input int rc, input int hold, input int first_chk);
    int t, h;
    t = (rc == 0) ? 1 : rc;
    h = (hold == 0) ? 1 : hold;
    bus8.mode     = 2'd3;
    bus8.hold_len = HOLD_W'(hold);
    bus8.rand_cnt = CNT_W'(rc);
    bus8.start    = 1'b1;
    tick();
    bus8.start = 1'b0;
    if (first_chk == 1) checkOutput("lfsr8_first_e1", 32'(bus8.vec), 32'h0000_00E1);
    if (first_chk == 2) checkOutput("lfsr8_continues", 32'(bus8.vec === 8'hE1), 32'd0);
    for (int k = 0; k < t; k++) begin
      for (int c = 0; c < h; c++) begin
        checkOutput("lfsr8_vec",   32'(bus8.vec), 32'(lfsr8_m[7:0]));
        checkOutput("lfsr8_idx",   32'(bus8.vec_idx), 32'(k));
        checkOutput("lfsr8_valid", 32'(bus8.vec_valid), 32'd1);
        tick();
      end
      if (k < t - 1) lfsr8_m = lfsr_step(lfsr8_m);
    end
    checkOutput("lfsr8_done", 32'(bus8.done), 32'd1);
    tick();
    checkOutput("lfsr8_post_done", 32'(bus8.done), 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    bus4.start = 1'b0; bus4.stop = 1'b0; bus4.mode = 2'd0; bus4.hold_len = '0; bus4.rand_cnt = '0;
    bus8.start = 1'b0; bus8.stop = 1'b0; bus8.mode = 2'd0; bus8.hold_len = '0; bus8.rand_cnt = '0;
    lfsr4_m = SEED;
    lfsr8_m = SEED;
    tick();
    tick();
    checkOutput("rst_vec",   32'(bus4.vec), 32'd0);
    checkOutput("rst_valid", 32'(bus4.vec_valid), 32'd0);
    checkOutput("rst_idx",   32'(bus4.vec_idx), 32'd0);
    checkOutput("rst_busy",  32'(bus4.busy), 32'd0);
    checkOutput("rst_done",  32'(bus4.done), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    runLfsr8(5, 1, 1);
    runLfsr8(4, 2, 2);

    applyStimulus(2'd0, 1, 0, -1);
    applyStimulus(2'd1, 2, 0, -1);
    applyStimulus(2'd2, 0, 0, -1);
    applyStimulus(2'd3, 1, 5, -1);
    applyStimulus(2'd3, 2, 0, -1);
    for (int r = 0; r < 4; r++)
      applyStimulus(2'($urandom), $urandom_range(0, 3), $urandom_range(0, 6), -1);

    applyStimulus(2'd0, 1, 0, 6);
    applyStimulus(2'd3, 2, 6, 3);
    applyStimulus(2'd3, 1, 3, -1);

    bus4.start = 1'b1;
    bus4.stop  = 1'b1;
    tick();
    checkOutput("startstop_busy",  32'(bus4.busy), 32'd0);
    checkOutput("startstop_valid", 32'(bus4.vec_valid), 32'd0);
    bus4.start = 1'b0;
    bus4.stop  = 1'b0;
    tick();
    checkOutput("startstop_idle", 32'(bus4.busy), 32'd0);
    checkOutput("startstop_done", 32'(bus4.done), 32'd0);

    bus4.mode     = 2'd0;
    bus4.hold_len = 8'd2;
    bus4.start    = 1'b1;
    tick();
    bus4.start = 1'b0;
    tick();
    tick();
    tick();
    checkOutput("pre_rst_busy", 32'(bus4.busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    checkOutput("async_rst_vec",   32'(bus4.vec), 32'd0);
    checkOutput("async_rst_valid", 32'(bus4.vec_valid), 32'd0);
    checkOutput("async_rst_idx",   32'(bus4.vec_idx), 32'd0);
    checkOutput("async_rst_busy",  32'(bus4.busy), 32'd0);
    checkOutput("async_rst_done",  32'(bus4.done), 32'd0);
    lfsr4_m = SEED;
    lfsr8_m = SEED;
    @(negedge clk);
    rst = 1'b1;
    tick();
    checkOutput("post_rst_done", 32'(bus4.done), 32'd0);
    applyStimulus(2'd0, 1, 0, -1);
    applyStimulus(2'd3, 1, 2, -1);
    runLfsr8(3, 1, 1);

    $display("[TB] %0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
